cpu_control_fsm: RTL and testbench
==================================

CPU_CONTROL_FSM -- requirements
Module: cpu_control_fsm

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 CLB  input  1  reset, synchronous, active-high; sampled on rising clk edge only.
REQ-003 input_ins  input  8  instruction byte: [7:4] op, [3:0] imm.
REQ-004 ins_valid  input  1  instruction source has a valid byte on input_ins.
REQ-005 ins_ready  output  1  controller accepts input_ins this cycle; transfer = ins_valid & ins_ready.
REQ-006 flag_z  input  1  registered accumulator-zero flag from datapath.
REQ-007 flag_c  input  1  registered carry flag from datapath.
REQ-008 alu_op  output  4  ALU operation select, held stable through EXEC.
REQ-009 alu_imm  output  8  imm zero-extended to 8 bits.
REQ-010 acc_we  output  1  accumulator write enable, one-cycle pulse.
REQ-011 pc_inc  output  1  PC increment, one-cycle pulse.
REQ-012 pc_load  output  1  PC load from alu_imm, one-cycle pulse.
REQ-013 halted  output  1  controller in HALT.
REQ-014 state_o  output  2  current state encoding, for debug/bench.

Function
REQ-015 States SHALL be FETCH(0), DECODE(1), EXEC(2), HALT(3).
REQ-016 FETCH: ins_ready=1; on transfer latch input_ins into internal ir and go DECODE; else stay FETCH.
REQ-017 DECODE: ins_ready=0; drive alu_op/alu_imm from ir; next state EXEC unconditionally.
REQ-018 EXEC: exactly one of {pc_inc, pc_load} =1; acc_we per op; next FETCH, or HALT for op HLT.
REQ-019 Opcodes: 0 NOP, 1 LDI, 2 ADDI, 3 SUBI, 4 ANDI, 5 ORI, 6 XORI, 7 SHL, 8 SHR, 9 JMP, A JZ, B JC, F HLT; C-E treated as NOP.
REQ-020 ops 1-8: acc_we=1, pc_inc=1 in EXEC; NOP and C-E: pc_inc only.
REQ-021 JMP: pc_load=1, pc_inc=0, acc_we=0.
REQ-022 JZ/JC: pc_load=1 if flag_z/flag_c sampled in EXEC is 1, else pc_inc=1.
REQ-023 HLT: pc_inc=0, pc_load=0, acc_we=0; enter HALT; halted=1 from next cycle.
REQ-024 HALT: all pulses 0, ins_ready=0; remain until CLB.
REQ-025 Latency: transfer at edge N -> acc_we/pc_* asserted in cycle N+2; one instruction per 3 cycles minimum.
REQ-026 ins_valid low in FETCH: stall indefinitely, no output pulses, ir unchanged.
REQ-027 ins_valid outside FETCH SHALL be ignored; input_ins not sampled.
REQ-028 alu_op/alu_imm SHALL hold previous ir value in FETCH and HALT.

Reset
REQ-029 CLB=1 at an edge: state FETCH, ir=8'h00, so alu_op=0, alu_imm=0; acc_we/pc_inc/pc_load=0, halted=0.
REQ-030 CLB mid-instruction (DECODE/EXEC/HALT) SHALL abort without emitting pulses that cycle; CLB dominates transfer.
REQ-031 ins_ready SHALL be 0 while CLB=1.

Configuration
REQ-032 Macro CPU_CTRL_BRANCH_EN: defined -> JZ/JC per REQ-022; undefined -> JZ/JC decode as NOP (pc_inc only), flag_z/flag_c unused.

Structure
REQ-033 Shared package cpu_pkg SHALL hold opcode constants, state enum typedef, and instruction field widths.
REQ-034 Sub-module cpu_ctrl_decode (combinational op -> control-bit decode) SHALL be instantiated once; FSM and ir stay in top.

Verification
REQ-035 Reset then ins_valid=1, input_ins=8'h15 -> state 0->1->2, acc_we=1 & pc_inc=1 exactly 2 cycles after transfer, alu_op=1, alu_imm=8'h05.
REQ-036 input_ins=8'h9A -> pc_load=1, alu_imm=8'h0A, pc_inc=0, acc_we=0.
REQ-037 input_ins=8'hA3 with flag_z=1 -> pc_load=1; repeat with flag_z=0 -> pc_inc=1; with macro undefined both cases -> pc_inc=1.
REQ-038 input_ins=8'hF0 -> HALT, halted=1, ins_ready=0 for 10 cycles despite ins_valid=1; CLB pulse -> FETCH, halted=0.
REQ-039 ins_valid=0 for 5 cycles in FETCH -> no pulses, state_o=0; CLB asserted in EXEC of 8'h21 -> no acc_we, state FETCH next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the accumulator CPU controller.
// Opcode map, FSM state encoding and instruction field widths.
package cpu_pkg;

    localparam int OP_W   = 4;
    localparam int IMM_W  = 4;
    localparam int INS_W  = OP_W + IMM_W;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

    localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OP_W-1:0] OP_LDI  = 4'h1;
    localparam logic [OP_W-1:0] OP_ADDI = 4'h2;
    localparam logic [OP_W-1:0] OP_SUBI = 4'h3;
    localparam logic [OP_W-1:0] OP_ANDI = 4'h4;
    localparam logic [OP_W-1:0] OP_ORI  = 4'h5;
    localparam logic [OP_W-1:0] OP_XORI = 4'h6;
    localparam logic [OP_W-1:0] OP_SHL  = 4'h7;
    localparam logic [OP_W-1:0] OP_SHR  = 4'h8;
    localparam logic [OP_W-1:0] OP_JMP  = 4'h9;
    localparam logic [OP_W-1:0] OP_JZ   = 4'hA;
    localparam logic [OP_W-1:0] OP_JC   = 4'hB;
    localparam logic [OP_W-1:0] OP_HLT  = 4'hF;

    function automatic logic [DATA_W-1:0] zext_imm(
        input logic [IMM_W-1:0] imm
    );
        return {{(DATA_W-IMM_W){1'b0}}, imm};
    endfunction

endpackage

// File: rtl/cpu_control_fsm_if.sv
// Instruction handshake and datapath control bundle.
// master = controller side, slave = instruction source / datapath side.
interface cpu_control_fsm_if;
    import cpu_pkg::*;

    logic [INS_W-1:0]  input_ins;
    logic              ins_valid;
    logic              ins_ready;
    logic              flag_z;
    logic              flag_c;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_imm;
    logic              acc_we;
    logic              pc_inc;
    logic              pc_load;
    logic              halted;
    logic [1:0]        state_o;

    modport master (
        input  input_ins, ins_valid, flag_z, flag_c,
        output ins_ready, alu_op, alu_imm,
        output acc_we, pc_inc, pc_load, halted, state_o
    );

    modport slave (
        output input_ins, ins_valid, flag_z, flag_c,
        input  ins_ready, alu_op, alu_imm,
        input  acc_we, pc_inc, pc_load, halted, state_o
    );

endinterface

// File: rtl/cpu_ctrl_decode.sv
// Opcode to EXEC-cycle control bits, purely combinational.
// CPU_CTRL_BRANCH_EN enables JZ/JC; without it they behave as NOP.
module cpu_ctrl_decode
    import cpu_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic            flag_z,
    input  logic            flag_c,
    output logic            acc_we,
    output logic            pc_inc,
    output logic            pc_load,
    output logic            is_hlt
);

`ifndef CPU_CTRL_BRANCH_EN
    logic unused_flags;
    assign unused_flags = flag_z ^ flag_c;
`endif

    // Map each opcode to its accumulator / PC effect.
    always_comb begin
        acc_we  = 1'b0;
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        is_hlt  = 1'b0;
        case (op)
            OP_LDI, OP_ADDI, OP_SUBI, OP_ANDI,
            OP_ORI, OP_XORI, OP_SHL, OP_SHR: begin
                acc_we = 1'b1;
                pc_inc = 1'b1;
            end
            OP_JMP: pc_load = 1'b1;
`ifdef CPU_CTRL_BRANCH_EN
            OP_JZ: begin
                pc_load = flag_z;
                pc_inc  = ~flag_z;
            end
            OP_JC: begin
                pc_load = flag_c;
                pc_inc  = ~flag_c;
            end
`endif
            OP_HLT: is_hlt = 1'b1;
            default: pc_inc = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// FETCH/DECODE/EXEC/HALT controller with instruction register.
// Optional branch support via macro CPU_CTRL_BRANCH_EN.
module cpu_control_fsm
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               CLB,
    cpu_control_fsm_if.master  bus
);

    state_t           state;
    state_t           state_nxt;
    logic [INS_W-1:0] ir;
    logic [INS_W-1:0] ir_nxt;

    logic dec_we;
    logic dec_inc;
    logic dec_ld;
    logic dec_hlt;

    logic ready;
    logic we;
    logic inc;
    logic ld;

    cpu_ctrl_decode u_dec (
        .op      (ir[INS_W-1:IMM_W]),
        .flag_z  (bus.flag_z),
        .flag_c  (bus.flag_c),
        .acc_we  (dec_we),
        .pc_inc  (dec_inc),
        .pc_load (dec_ld),
        .is_hlt  (dec_hlt)
    );

    // State and instruction register; reset wins over any transfer.
    always_ff @(posedge clk) begin
        if (CLB) begin
            state <= ST_FETCH;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            ir    <= ir_nxt;
        end
    end

    // Next state, handshake and EXEC pulses; reset suppresses pulses.
    always_comb begin
        state_nxt = state;
        ir_nxt    = ir;
        ready     = 1'b0;
        we        = 1'b0;
        inc       = 1'b0;
        ld        = 1'b0;
        case (state)
            ST_FETCH: begin
                ready = ~CLB;
                if (bus.ins_valid) begin
                    ir_nxt    = bus.input_ins;
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: state_nxt = ST_EXEC;
            ST_EXEC: begin
                we        = dec_we  & ~CLB;
                inc       = dec_inc & ~CLB;
                ld        = dec_ld  & ~CLB;
                state_nxt = dec_hlt ? ST_HALT : ST_FETCH;
            end
            default: state_nxt = ST_HALT;
        endcase
    end

    assign bus.ins_ready = ready;
    assign bus.acc_we    = we;
    assign bus.pc_inc    = inc;
    assign bus.pc_load   = ld;
    assign bus.alu_op    = ir[INS_W-1:IMM_W];
    assign bus.alu_imm   = zext_imm(ir[IMM_W-1:0]);
    assign bus.halted    = (state == ST_HALT);
    assign bus.state_o   = state;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed testbench for cpu_control_fsm.
// Expected branch behaviour follows CPU_CTRL_BRANCH_EN.
module tb_cpu_control_fsm;

`ifdef CPU_CTRL_BRANCH_EN
    localparam bit BR = 1'b1;
`else
    localparam bit BR = 1'b0;
`endif

    logic clk = 1'b0;
    logic CLB = 1'b1;
    int   total = 0;
    int   bad = 0;

    cpu_control_fsm_if bus ();

    cpu_control_fsm dut (
        .clk (clk),
        .CLB (CLB),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] pulses();
        return {bus.acc_we, bus.pc_inc, bus.pc_load};
    endfunction

    task automatic run_ins(
        input logic [7:0] ins,
        input logic       fz,
        input logic       fc,
        input logic [2:0] exp_p,
        input logic [1:0] exp_nx
    );
        logic [7:0] imm;
        imm = {4'h0, ins[3:0]};
        bus.ins_valid = 1'b1;
        bus.input_ins = ins;
        tick();
        bus.ins_valid = 1'b0;
        chk("dec_state", bus.state_o, 2'd1);
        chk("dec_op", bus.alu_op, ins[7:4]);
        chk("dec_imm", bus.alu_imm, imm);
        chk("dec_rdy", bus.ins_ready, 1'b0);
        chk("dec_pulse", pulses(), 3'b000);
        bus.flag_z = fz;
        bus.flag_c = fc;
        tick();
        chk("ex_state", bus.state_o, 2'd2);
        chk("ex_op", bus.alu_op, ins[7:4]);
        chk("ex_pulse", pulses(), exp_p);
        tick();
        chk("nx_state", bus.state_o, exp_nx);
        chk("nx_pulse", pulses(), 3'b000);
        chk("nx_op_hold", bus.alu_op, ins[7:4]);
    endtask

    initial begin
        bus.ins_valid = 1'b1;
        bus.input_ins = 8'h5A;
        bus.flag_z    = 1'b0;
        bus.flag_c    = 1'b0;

        tick();
        tick();
        chk("rst_state", bus.state_o, 2'd0);
        chk("rst_op", bus.alu_op, 4'h0);
        chk("rst_imm", bus.alu_imm, 8'h00);
        chk("rst_pulse", pulses(), 3'b000);
        chk("rst_halt", bus.halted, 1'b0);
        chk("rst_rdy", bus.ins_ready, 1'b0);
        bus.ins_valid = 1'b0;
        CLB = 1'b0;
        #1;
        chk("fetch_rdy", bus.ins_ready, 1'b1);

        run_ins(8'h15, 1'b0, 1'b0, 3'b110, 2'd0);
        chk("ldi_imm", bus.alu_imm, 8'h05);

        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_state", bus.state_o, 2'd0);
            chk("stall_pulse", pulses(), 3'b000);
            chk("stall_op", bus.alu_op, 4'h1);
        end

        run_ins(8'h9A, 1'b0, 1'b0, 3'b001, 2'd0);
        chk("jmp_imm", bus.alu_imm, 8'h0A);
        run_ins(8'hA3, 1'b1, 1'b0, {1'b0, ~BR, BR}, 2'd0);
        run_ins(8'hA3, 1'b0, 1'b1, 3'b010, 2'd0);
        run_ins(8'hB7, 1'b0, 1'b1, {1'b0, ~BR, BR}, 2'd0);
        run_ins(8'hB7, 1'b1, 1'b0, 3'b010, 2'd0);
        run_ins(8'hC4, 1'b1, 1'b1, 3'b010, 2'd0);
        run_ins(8'h00, 1'b0, 1'b0, 3'b010, 2'd0);
        run_ins(8'h8F, 1'b0, 1'b0, 3'b110, 2'd0);

        bus.ins_valid = 1'b1;
        bus.input_ins = 8'h34;
        tick();
        bus.input_ins = 8'h77;
        tick();
        chk("ign_state", bus.state_o, 2'd2);
        chk("ign_op", bus.alu_op, 4'h3);
        chk("ign_imm", bus.alu_imm, 8'h04);
        chk("ign_pulse", pulses(), 3'b110);
        bus.ins_valid = 1'b0;
        tick();
        chk("ign_back", bus.state_o, 2'd0);

        run_ins(8'hF0, 1'b0, 1'b0, 3'b000, 2'd3);
        bus.ins_valid = 1'b1;
        bus.input_ins = 8'h15;
        for (int i = 0; i < 10; i++) begin
            chk("halt_flag", bus.halted, 1'b1);
            chk("halt_rdy", bus.ins_ready, 1'b0);
            chk("halt_pulse", pulses(), 3'b000);
            chk("halt_state", bus.state_o, 2'd3);
            tick();
        end
        bus.ins_valid = 1'b0;
        CLB = 1'b1;
        tick();
        CLB = 1'b0;
        #1;
        chk("unhalt_state", bus.state_o, 2'd0);
        chk("unhalt_flag", bus.halted, 1'b0);

        bus.ins_valid = 1'b1;
        bus.input_ins = 8'h21;
        tick();
        bus.ins_valid = 1'b0;
        tick();
        chk("abort_pre", bus.state_o, 2'd2);
        CLB = 1'b1;
        bus.ins_valid = 1'b1;
        bus.input_ins = 8'h66;
        #1;
        chk("abort_pulse", pulses(), 3'b000);
        chk("abort_rdy", bus.ins_ready, 1'b0);
        tick();
        chk("abort_state", bus.state_o, 2'd0);
        chk("abort_op", bus.alu_op, 4'h0);
        tick();
        chk("clb_dom_state", bus.state_o, 2'd0);
        chk("clb_dom_op", bus.alu_op, 4'h0);
        CLB = 1'b0;
        bus.ins_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
